// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM stage plus MEM/WB pipeline register of the RV32I core.
// Runs loads and stores on a req/ack data bus and stalls the core while an
// access is outstanding. It formats store lanes and load data, flags
// misaligned accesses, and flags bus timeouts. Upstream stages hold the MEM
// inputs stable while mem_stall is high. The in-flight instruction's fields
// are therefore read straight from the MEM inputs for the whole access.
module mem_wb_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEMvalid,
  input  logic [31:0] MEMpc4,
  input  logic [31:0] MEMinst,
  input  logic [1:0]  MEMwd_sel,
  input  logic        MEMrf_we,
  input  logic        MEMdram_we,
  input  logic [31:0] MEMext,
  input  logic [31:0] MEMrf_rD2,
  input  logic [31:0] MEMalu_c,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_wstrb,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic        WBvalid,
  output logic        WBrf_we,
  output logic [4:0]  WBwR,
  output logic [31:0] WBwd,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  localparam logic [8:0] TMO = 9'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wbvalid_q, wbvalid_d;
  logic        wbrfwe_q, wbrfwe_d;
  logic [4:0]  wbwr_q, wbwr_d;
  logic [31:0] wbwd_q, wbwd_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;

  logic [2:0]  funct3;
  logic [1:0]  off;
  logic        is_store, is_load, mem_op, misaligned;
  logic [31:0] st_wdata, ld_data, sel_data, rd_shift;
  logic [3:0]  st_wstrb;
  logic [8:0]  cnt_inc;

  assign funct3   = MEMinst[14:12];
  assign off      = MEMalu_c[1:0];
  assign is_store = MEMdram_we;
  // A store request takes priority over the opcode if both claim the slot.
  assign is_load  = (MEMinst[6:0] == 7'b0000011) && !MEMdram_we;
  assign mem_op   = MEMvalid && (is_load || is_store);
  // Size lives in funct3[1:0]; the reserved size 11 is checked like a word.
  assign misaligned = (funct3[1:0] == 2'b01) ? off[0] :
                      (funct3[1:0] == 2'b00) ? 1'b0 : (off != 2'b00);
  assign rd_shift = dbus_rdata >> {off, 3'b000};
  assign cnt_inc  = {1'b0, cnt_q} + 9'd1;

  // Replicate store data into every lane and pick byte strobes by address.
  always_comb begin
    st_wdata = MEMrf_rD2;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{MEMrf_rD2[7:0]}};
        st_wstrb = 4'b0001 << off;
      end
      2'b01: begin
        st_wdata = {2{MEMrf_rD2[15:0]}};
        st_wstrb = off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Extract and extend the addressed load lane.
  always_comb begin
    case (funct3)
      3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_data = {24'h0, rd_shift[7:0]};
      3'b101:  ld_data = {16'h0, rd_shift[15:0]};
      default: ld_data = dbus_rdata;
    endcase
  end

  // Write-back select for non-load results; select 1 has no source outside loads.
  always_comb begin
    case (MEMwd_sel)
      2'd2:    sel_data = MEMpc4;
      2'd3:    sel_data = MEMext;
      default: sel_data = MEMalu_c;
    endcase
  end

  // Access FSM, bus drive, stall and next values of the WB register.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wbvalid_d = 1'b0;
    wbrfwe_d  = 1'b0;
    wbwr_d    = MEMinst[11:7];
    wbwd_d    = sel_data;
    mis_d     = 1'b0;
    berr_d    = berr_q;
    mem_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op && !misaligned) begin
          // Launch the access; WB sees a bubble until the ack.
          mem_stall = 1'b1;
          state_d   = S_WAIT;
          cnt_d     = 8'd0;
          req_d     = 1'b1;
          we_d      = is_store;
          addr_d    = {MEMalu_c[31:2], 2'b00};
          wdata_d   = st_wdata;
          wstrb_d   = is_store ? st_wstrb : 4'b0000;
        end else if (mem_op) begin
          // Misaligned: drop the access but retire the slot with no write.
          mis_d     = 1'b1;
          wbvalid_d = 1'b1;
        end else begin
          wbvalid_d = MEMvalid;
          wbrfwe_d  = MEMrf_we && MEMvalid;
        end
      end
      S_WAIT: begin
        if (dbus_ack) begin
          state_d   = S_IDLE;
          cnt_d     = 8'd0;
          req_d     = 1'b0;
          we_d      = 1'b0;
          wbvalid_d = MEMvalid;
          wbrfwe_d  = MEMvalid && MEMrf_we && !is_store;
          if (is_load) wbwd_d = ld_data;
        end else begin
          mem_stall = 1'b1;
          cnt_d     = cnt_inc[7:0];
          if (cnt_inc >= TMO) begin
            state_d = S_ERR;
            req_d   = 1'b0;
            we_d    = 1'b0;
            berr_d  = 1'b1;
          end
        end
      end
      S_ERR: begin
        // Core stays halted until reset.
        mem_stall = 1'b1;
        berr_d    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      wbvalid_q <= 1'b0;
      wbrfwe_q  <= 1'b0;
      wbwr_q    <= 5'h0;
      wbwd_q    <= 32'h0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wbvalid_q <= wbvalid_d;
      wbrfwe_q  <= wbrfwe_d;
      wbwr_q    <= wbwr_d;
      wbwd_q    <= wbwd_d;
      mis_q     <= mis_d;
      berr_q    <= berr_d;
    end
  end

  assign dbus_req     = req_q;
  assign dbus_we      = we_q;
  assign dbus_addr    = addr_q;
  assign dbus_wdata   = wdata_q;
  assign dbus_wstrb   = wstrb_q;
  assign WBvalid      = wbvalid_q;
  assign WBrf_we      = wbrfwe_q;
  assign WBwR         = wbwr_q;
  assign WBwd         = wbwd_q;
  assign misalign_err = mis_q;
  assign bus_err      = berr_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios followed by random ALU, load,
// store and misaligned operations, each checked against a reference model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEMvalid, MEMrf_we, MEMdram_we, dbus_ack;
  logic [31:0] MEMpc4, MEMinst, MEMext, MEMrf_rD2, MEMalu_c, dbus_rdata;
  logic [1:0]  MEMwd_sel;
  logic        dbus_req, dbus_we, mem_stall, WBvalid, WBrf_we, misalign_err, bus_err;
  logic [31:0] dbus_addr, dbus_wdata, WBwd;
  logic [3:0]  dbus_wstrb;
  logic [4:0]  WBwR;

  int total = 0;
  int bad   = 0;

  mem_wb_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .MEMvalid(MEMvalid), .MEMpc4(MEMpc4), .MEMinst(MEMinst),
    .MEMwd_sel(MEMwd_sel), .MEMrf_we(MEMrf_we), .MEMdram_we(MEMdram_we), .MEMext(MEMext),
    .MEMrf_rD2(MEMrf_rD2), .MEMalu_c(MEMalu_c), .dbus_req(dbus_req), .dbus_we(dbus_we),
    .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .mem_stall(mem_stall), .WBvalid(WBvalid),
    .WBrf_we(WBrf_we), .WBwR(WBwR), .WBwd(WBwd), .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference load formatting: pick the addressed lane arithmetically and extend.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (8 * off)) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd1: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] mk_inst(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
    return {17'h0, f3, rd, opc};
  endfunction

  task automatic idle_inputs();
    MEMvalid = 0; MEMinst = 0; MEMdram_we = 0; MEMwd_sel = 0; MEMrf_we = 0;
    MEMalu_c = 0; MEMrf_rD2 = 0; MEMext = 0; MEMpc4 = 0;
  endtask

  // Drive one instruction, hold it through the access, ack after dly idle WAIT cycles.
  task automatic run_op(input logic [31:0] inst, input logic st, input logic [1:0] sel,
                        input logic rfwe, input logic [31:0] alu, input logic [31:0] rd2,
                        input logic [31:0] rdata, input int dly);
    logic ld, mop, mis;
    int sz, off;
    logic [31:0] e_wd, e_wdata, pc4, ext;
    logic [3:0] e_strb;
    pc4 = $urandom; ext = $urandom;
    sz  = int'(inst[13:12]);
    off = int'(alu[1:0]);
    ld  = (inst[6:0] == 7'b0000011) && !st;
    mop = ld || st;
    mis = mop && ((sz == 1 && (off % 2) != 0) || (sz >= 2 && off != 0));
    if (ld) e_wd = ref_load(inst[14:12], off, rdata);
    else if (sel == 2) e_wd = pc4;
    else if (sel == 3) e_wd = ext;
    else e_wd = alu;
    if (sz == 0) begin e_wdata = (rd2 & 32'hFF) * 32'h0101_0101; e_strb = 4'(1 << off); end
    else if (sz == 1) begin e_wdata = (rd2 & 32'hFFFF) * 32'h0001_0001; e_strb = 4'(3 << off); end
    else begin e_wdata = rd2; e_strb = 4'hF; end

    @(negedge clk);
    MEMvalid = 1; MEMinst = inst; MEMdram_we = st; MEMwd_sel = sel; MEMrf_we = rfwe;
    MEMalu_c = alu; MEMrf_rD2 = rd2; MEMext = ext; MEMpc4 = pc4;
    #1;
    if (!mop || mis) begin
      chk("stall_direct", 32'(mem_stall), 32'(0));
      @(posedge clk); #1;
      chk("wb_valid", 32'(WBvalid), 32'(1));
      chk("wb_rfwe", 32'(WBrf_we), 32'(mis ? 1'b0 : rfwe));
      chk("wb_wr", 32'(WBwR), 32'(inst[11:7]));
      chk("misalign", 32'(misalign_err), 32'(mis));
      chk("req_direct", 32'(dbus_req), 32'(0));
      if (!mis) chk("wb_wd", WBwd, e_wd);
    end else begin
      chk("stall_idle", 32'(mem_stall), 32'(1));
      @(posedge clk); #1;
      chk("req_start", 32'(dbus_req), 32'(1));
      chk("we", 32'(dbus_we), 32'(st));
      chk("addr", dbus_addr, {alu[31:2], 2'b00});
      chk("wb_bubble", 32'(WBvalid), 32'(0));
      chk("misalign_quiet", 32'(misalign_err), 32'(0));
      if (st) begin
        chk("wdata", dbus_wdata, e_wdata);
        chk("wstrb", 32'(dbus_wstrb), 32'(e_strb));
      end
      for (int k = 0; k < dly; k++) begin
        @(negedge clk); #1;
        chk("stall_wait", 32'(mem_stall), 32'(1));
        @(posedge clk); #1;
        chk("req_hold", 32'(dbus_req), 32'(1));
        chk("addr_hold", dbus_addr, {alu[31:2], 2'b00});
      end
      @(negedge clk);
      dbus_ack = 1; dbus_rdata = rdata;
      #1;
      chk("stall_ack", 32'(mem_stall), 32'(0));
      @(posedge clk); #1;
      dbus_ack = 0; dbus_rdata = $urandom;
      chk("req_done", 32'(dbus_req), 32'(0));
      chk("wb_valid_mem", 32'(WBvalid), 32'(1));
      chk("wb_rfwe_mem", 32'(WBrf_we), 32'(st ? 1'b0 : rfwe));
      chk("wb_wr_mem", 32'(WBwR), 32'(inst[11:7]));
      chk("wb_wd_mem", WBwd, e_wd);
    end
  endtask

  initial begin
    logic [2:0] f3;
    logic [31:0] a;
    logic st;
    int kind;
    rst = 1; dbus_ack = 0; dbus_rdata = 0;
    idle_inputs();
    #1;
    chk("rst_req", 32'(dbus_req), 32'(0));
    chk("rst_addr", dbus_addr, 32'h0);
    chk("rst_wbvalid", 32'(WBvalid), 32'(0));
    chk("rst_wd", WBwd, 32'h0);
    chk("rst_buserr", 32'(bus_err), 32'(0));
    chk("rst_mis", 32'(misalign_err), 32'(0));
    @(negedge clk); @(negedge clk);
    rst = 0;

    // ALU op
    run_op(mk_inst(7'b0110011, 3'd0, 5'd5), 1'b0, 2'd0, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 0);
    // LB, ack in first WAIT cycle
    run_op(mk_inst(7'b0000011, 3'd0, 5'd7), 1'b0, 2'd1, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);
    // SH held for three request cycles
    run_op(mk_inst(7'b0100011, 3'd1, 5'd0), 1'b1, 2'd0, 1'b0, 32'h0000_0202, 32'hABCD_1234, 32'h0, 2);
    // Misaligned LW, then a bubble must clear the error pulse
    run_op(mk_inst(7'b0000011, 3'd2, 5'd9), 1'b0, 2'd1, 1'b1, 32'h0000_0006, 32'h0, 32'h0, 0);
    @(negedge clk); idle_inputs();
    @(posedge clk); #1;
    chk("mis_pulse_end", 32'(misalign_err), 32'(0));
    chk("bubble_valid", 32'(WBvalid), 32'(0));

    // Random mix
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      a = $urandom;
      case (kind)
        0: run_op(mk_inst(7'b0010011, 3'($urandom), 5'($urandom)), 1'b0, 2'($urandom_range(0, 1)) * 2'd2 + 2'($urandom_range(0, 1)) * 2'd1 == 2'd1 ? 2'd0 : 2'($urandom_range(2, 3)),
                  1'($urandom), a, 32'h0, 32'h0, 0);
        1: begin
          case ($urandom_range(0, 4))
            0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
          endcase
          if (f3[1:0] == 2'd1) a[0] = 1'b0;
          if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
          run_op(mk_inst(7'b0000011, f3, 5'($urandom)), 1'b0, 2'd1, 1'($urandom), a, 32'h0,
                 $urandom, $urandom_range(0, 2));
        end
        2: begin
          f3 = 3'($urandom_range(0, 2));
          if (f3 == 3'd1) a[0] = 1'b0;
          if (f3 == 3'd2) a[1:0] = 2'b00;
          run_op(mk_inst(7'b0100011, f3, 5'($urandom)), 1'b1, 2'd0, 1'b0, a, $urandom, 32'h0,
                 $urandom_range(0, 2));
        end
        default: begin
          f3 = 3'($urandom_range(1, 2));
          a[0] = 1'b1;
          st = 1'($urandom);
          run_op(mk_inst(st ? 7'b0100011 : 7'b0000011, f3, 5'($urandom)), st, 2'd1, ~st, a,
                 $urandom, 32'h0, 0);
        end
      endcase
    end

    // Timeout: load never acknowledged, four WAIT cycles then ERR
    @(negedge clk);
    idle_inputs();
    MEMvalid = 1; MEMinst = mk_inst(7'b0000011, 3'd2, 5'd3); MEMrf_we = 1; MEMwd_sel = 1;
    MEMalu_c = 32'h0000_0040;
    #1;
    chk("tmo_stall0", 32'(mem_stall), 32'(1));
    @(posedge clk); #1;
    chk("tmo_req0", 32'(dbus_req), 32'(1));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      chk("tmo_stall", 32'(mem_stall), 32'(1));
      @(posedge clk); #1;
      chk("tmo_req", 32'(dbus_req), 32'(k < 4));
      chk("tmo_berr", 32'(bus_err), 32'(k == 4));
    end
    @(negedge clk); dbus_ack = 1; #1;
    chk("err_stall", 32'(mem_stall), 32'(1));
    @(posedge clk); #1; dbus_ack = 0;
    chk("err_ack_ignored", 32'(WBvalid), 32'(0));
    chk("err_sticky", 32'(bus_err), 32'(1));
    @(negedge clk); rst = 1; idle_inputs(); #1;
    chk("err_rst_berr", 32'(bus_err), 32'(0));
    chk("err_rst_stall", 32'(mem_stall), 32'(0));
    @(negedge clk); rst = 0;

    // Reset in the middle of WAIT, then a stray ack
    @(negedge clk);
    MEMvalid = 1; MEMinst = mk_inst(7'b0000011, 3'd2, 5'd4); MEMrf_we = 1; MEMwd_sel = 1;
    MEMalu_c = 32'h0000_0080;
    @(posedge clk); #1;
    chk("mid_req", 32'(dbus_req), 32'(1));
    #2; rst = 1; idle_inputs(); #1;
    chk("mid_rst_req", 32'(dbus_req), 32'(0));
    chk("mid_rst_addr", dbus_addr, 32'h0);
    @(negedge clk); rst = 0;
    @(negedge clk); dbus_ack = 1; dbus_rdata = 32'hDEAD_BEEF; #1;
    chk("stray_stall", 32'(mem_stall), 32'(0));
    @(posedge clk); #1; dbus_ack = 0;
    chk("stray_req", 32'(dbus_req), 32'(0));
    chk("stray_valid", 32'(WBvalid), 32'(0));
    chk("stray_rfwe", 32'(WBrf_we), 32'(0));
    chk("stray_wd", WBwd, 32'h0);
    // After the stray ack the FSM must still launch a fresh access from IDLE.
    run_op(mk_inst(7'b0000011, 3'd5, 5'd11), 1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0, 32'h8001_7FFF, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
